issue_queue: RTL and testbench
==============================

# issue_queue

Parametrised instruction queue and dispatch stage between the IFetcher and the ROB/RS/LSB. It buffers up to DEPTH fetched instructions, so fetch no longer stalls the moment the back end is full. Each cycle it dispatches the head instruction when every structure that instruction needs has room. At dispatch it captures source operands from the register file, the NUM_CDB broadcast channels, or the instruction dispatched in the previous cycle.

## Interface
- DEPTH, 4: queue entries; power of two, ≥2.
- ROB_W, 4: ROB tag width.
- NUM_CDB, 2: number of CDB broadcast channels.

- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high.
- rdy  in  1  when low, all state and outputs hold.
- clr  in  1  flush on mispredict: empties the queue and cancels any dispatch in that cycle.
- IF_ins_sgn  in  1  push request.
- IF_ins, IF_pc, IF_jump_pc  in  32 each  instruction, its PC, predicted target.
- IF_jump_flag  in  1  predicted taken.
- IF_full  out  1  combinational; equals count==DEPTH.
- ROB_full, RS_full, LSB_full  in  1 each  back-end occupancy.
- ROB_name  in  ROB_W  tag the ROB will allocate next.
- REG_rs1, REG_rs2  out  5 each  combinational; head rs1 field ins[19:15] and rs2 field ins[24:20].
- REG_rs1_rdy, REG_rs2_rdy  in  1; REG_rs1_val, REG_rs2_val  in  32  value when ready, else tag in [ROB_W-1:0].
- CDB_sgn  in  NUM_CDB; CDB_result  in  NUM_CDB*32; CDB_ROB_name  in  NUM_CDB*ROB_W.
- DP_sgn  out  1  registered one-cycle dispatch pulse.
- DP_ins, DP_pc, DP_jump_pc  out  32; DP_jump_flag  out  1.
- DP_class  out  2  0 ROB-only, 1 RS, 2 RS+LSB.
- DP_rs1_val, DP_rs2_val  out  32; DP_rs1_rdy, DP_rs2_rdy  out  1.
- DP_illegal_cnt  out  16  count of dropped illegal opcodes; saturates at 16'hFFFF.

## Operation
- **Storage:** circular FIFO with head and tail pointers of log2(DEPTH) bits and a count of log2(DEPTH)+1 bits. Pointers wrap modulo DEPTH.
- **Push:** when IF_ins_sgn && count<DEPTH && !clr. A push while count==DEPTH is dropped, even if a pop happens in the same cycle.
- **Classification** of the head by opcode ins[6:0]:
  - Class 0: LUI 0110111, AUIPC 0010111, JAL 1101111.
  - Class 1: JALR 1100111, BR 1100011, I 0010011, R 0110011.
  - Class 2: LOAD 0000011, STORE 0100011.
  - Any other opcode is illegal.
- **Dispatch condition:** count>0 && !clr && !ROB_full && (class≥1 → !RS_full) && (class==2 → !LSB_full).
  - On dispatch: pop, DP_sgn<=1, copy the entry to DP_*.
  - Illegal head: popped with DP_sgn<=0; DP_illegal_cnt increments; ROB/RS/LSB fullness is ignored.
- **Operand capture, per source, first match wins:**
  1. Field is 0 → rdy=1, val=0.
  2. Bypass: the previous cycle dispatched an instruction (DP_sgn==1) that writes rd≠0, and rd equals this field → rdy=0, val=last_tag. Writers are every opcode except BR and STORE.
  3. REG rdy → REG val.
  4. Lowest-index CDB channel k with CDB_sgn[k] and CDB_ROB_name[k] equal to the REG tag → rdy=1, val=CDB_result[k].
  5. Otherwise → rdy=0, val=REG val.
- **last_tag:** latched from ROB_name at each dispatch. last_rd and last_writes are latched at each dispatch and cleared when nothing is dispatched.
- **clr:** head, tail and count go to 0; DP_sgn<=0; a push in the same cycle is dropped.
- **Reset, synchronous:**
  - Pointers, count, DP_sgn, DP_class, all DP_* data, DP_illegal_cnt and last_* go to 0.
  - IF_full is 0 after reset.
  - Asserting rst mid-burst discards all entries.

## Timing
- Fetch to dispatch latency: a push at edge N is dispatchable at edge N+1, so DP_sgn is high in cycle N+1..N+2 at the earliest.
- Sustained throughput is 1 dispatch per cycle.
- Push and pop in the same cycle leave count unchanged.
- DP_* are valid only while DP_sgn=1; downstream samples them at the next edge.
- Back-to-back dependent instructions are correct through the bypass path; no bubble is inserted.
- rdy low: no push, no pop, DP_sgn holds its value, counters hold.

## Test plan
- **Fill and drain:** DEPTH=4, ROB_full=1, push 5 instructions.
  - IF_full=1 after the 4th push; the 5th is dropped.
  - Release ROB_full: 4 DP_sgn pulses in consecutive cycles, in push order.
- **Dependency bypass:** addi x5,x0,1 (ROB_name=3), then add x6,x5,x5 back-to-back, REG reports x5 ready with stale value 9.
  - Second dispatch has DP_rs1_rdy=DP_rs2_rdy=0 and val=3.
- **CDB capture:** REG rs1 not ready with tag 2; CDB0 and CDB1 both broadcast tag 2 with results 0x11 and 0x22.
  - DP_rs1_val=0x11, rdy=1.
- **Structural stall:** head is a LOAD with LSB_full=1 and RS/ROB free.
  - No dispatch until LSB_full drops; then DP_class=2 the next cycle.
- **Flush:** 3 entries queued, clr asserted together with IF_ins_sgn.
  - count=0, IF_full=0, no DP_sgn the following cycle.
- **Illegal opcode and reset:** push opcode 1111111 → DP_illegal_cnt=1, no DP_sgn.
  - Assert rst with 2 entries queued → all outputs 0 next cycle.

Source files
------------

// File: rtl/issue_queue.sv
`default_nettype none
// ============================================================================
//  Module   : issue_queue
//  Purpose  : Instruction queue and dispatch stage between fetch and the
//             ROB/RS/LSB. Buffers fetched instructions in a circular FIFO,
//             dispatches the head when the back end has room, and captures
//             source operands from the register file, the CDB channels or
//             the instruction dispatched in the previous cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module issue_queue #(
    parameter int DEPTH   = 4,
    parameter int ROB_W   = 4,
    parameter int NUM_CDB = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rdy,
    input  logic                     clr,
    // fetch side
    input  logic                     IF_ins_sgn,
    input  logic [31:0]              IF_ins,
    input  logic [31:0]              IF_pc,
    input  logic [31:0]              IF_jump_pc,
    input  logic                     IF_jump_flag,
    output logic                     IF_full,
    // back-end occupancy
    input  logic                     ROB_full,
    input  logic                     RS_full,
    input  logic                     LSB_full,
    input  logic [ROB_W-1:0]         ROB_name,
    // register file lookup
    output logic [4:0]               REG_rs1,
    output logic [4:0]               REG_rs2,
    input  logic                     REG_rs1_rdy,
    input  logic                     REG_rs2_rdy,
    input  logic [31:0]              REG_rs1_val,
    input  logic [31:0]              REG_rs2_val,
    // common data bus
    input  logic [NUM_CDB-1:0]       CDB_sgn,
    input  logic [NUM_CDB*32-1:0]    CDB_result,
    input  logic [NUM_CDB*ROB_W-1:0] CDB_ROB_name,
    // dispatch outputs
    output logic                     DP_sgn,
    output logic [31:0]              DP_ins,
    output logic [31:0]              DP_pc,
    output logic [31:0]              DP_jump_pc,
    output logic                     DP_jump_flag,
    output logic [1:0]               DP_class,
    output logic [31:0]              DP_rs1_val,
    output logic [31:0]              DP_rs2_val,
    output logic                     DP_rs1_rdy,
    output logic                     DP_rs2_rdy,
    output logic [15:0]              DP_illegal_cnt
);

    localparam int                 c_PTR_W = $clog2(DEPTH);
    localparam logic [c_PTR_W:0]   c_FULL  = (c_PTR_W+1)'(DEPTH);

    localparam logic [6:0] c_OP_LUI   = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC = 7'b0010111;
    localparam logic [6:0] c_OP_JAL   = 7'b1101111;
    localparam logic [6:0] c_OP_JALR  = 7'b1100111;
    localparam logic [6:0] c_OP_BR    = 7'b1100011;
    localparam logic [6:0] c_OP_IMM   = 7'b0010011;
    localparam logic [6:0] c_OP_REG   = 7'b0110011;
    localparam logic [6:0] c_OP_LOAD  = 7'b0000011;
    localparam logic [6:0] c_OP_STORE = 7'b0100011;

    localparam logic [1:0] c_CLS_ROB = 2'd0;
    localparam logic [1:0] c_CLS_RS  = 2'd1;
    localparam logic [1:0] c_CLS_LSB = 2'd2;

    // queue storage
    logic [31:0]        r_ins   [DEPTH];
    logic [31:0]        r_pc    [DEPTH];
    logic [31:0]        r_jpc   [DEPTH];
    logic               r_jflag [DEPTH];
    logic [c_PTR_W-1:0] r_head;
    logic [c_PTR_W-1:0] r_tail;
    logic [c_PTR_W:0]   r_count;

    // record of the previous dispatch for the back-to-back bypass
    logic [4:0]         r_last_rd;
    logic               r_last_writes;
    logic [ROB_W-1:0]   r_last_tag;

    logic [31:0]        w_head_ins;
    logic [1:0]         w_class;
    logic               w_illegal;
    logic               w_writes;
    logic               w_empty;
    logic               w_push;
    logic               w_room;
    logic               w_dispatch;
    logic               w_drop;
    logic               w_pop;
    logic               w_byp_valid;
    logic               w_rs1_rdy;
    logic               w_rs2_rdy;
    logic [31:0]        w_rs1_val;
    logic [31:0]        w_rs2_val;

    assign w_head_ins = r_ins[r_head];
    assign REG_rs1    = w_head_ins[19:15];
    assign REG_rs2    = w_head_ins[24:20];
    assign IF_full    = (r_count == c_FULL);
    assign w_empty    = (r_count == '0);

    // Decode the head opcode into its back-end class or flag it illegal.
    always_comb begin
        w_class   = c_CLS_ROB;
        w_illegal = 1'b0;
        case (w_head_ins[6:0])
            c_OP_LUI, c_OP_AUIPC, c_OP_JAL:          w_class = c_CLS_ROB;
            c_OP_JALR, c_OP_BR, c_OP_IMM, c_OP_REG:  w_class = c_CLS_RS;
            c_OP_LOAD, c_OP_STORE:                   w_class = c_CLS_LSB;
            default:                                 w_illegal = 1'b1;
        endcase
    end

    // Branches and stores are the only legal opcodes without a destination.
    assign w_writes = (w_head_ins[6:0] != c_OP_BR) && (w_head_ins[6:0] != c_OP_STORE);

    // A full queue refuses a push even if the head leaves in the same cycle.
    assign w_push     = rdy && !clr && IF_ins_sgn && (r_count != c_FULL);
    assign w_room     = !ROB_full
                      && ((w_class == c_CLS_ROB) || !RS_full)
                      && ((w_class != c_CLS_LSB) || !LSB_full);
    assign w_dispatch = rdy && !clr && !w_empty && !w_illegal && w_room;
    assign w_drop     = rdy && !clr && !w_empty && w_illegal;
    assign w_pop      = w_dispatch || w_drop;

    assign w_byp_valid = DP_sgn && r_last_writes && (r_last_rd != 5'd0);

    // Resolve one source operand; returns {ready, value}.
    function automatic logic [32:0] f_capture(
        input logic [4:0]               field,
        input logic                     reg_rdy,
        input logic [31:0]              reg_val,
        input logic                     byp_valid,
        input logic [4:0]               byp_rd,
        input logic [ROB_W-1:0]         byp_tag,
        input logic [NUM_CDB-1:0]       cdb_sgn,
        input logic [NUM_CDB*32-1:0]    cdb_res,
        input logic [NUM_CDB*ROB_W-1:0] cdb_name
    );
        logic [32:0] res;
        res = {1'b0, reg_val};
        if (field == 5'd0) begin
            res = {1'b1, 32'd0};
        end else if (byp_valid && (byp_rd == field)) begin
            res = {1'b0, 32'(byp_tag)};
        end else if (reg_rdy) begin
            res = {1'b1, reg_val};
        end else begin
            // scan high to low so the lowest matching channel has the last word
            for (int k = NUM_CDB - 1; k >= 0; k--) begin
                if (cdb_sgn[k] && (cdb_name[k*ROB_W +: ROB_W] == reg_val[ROB_W-1:0])) begin
                    res = {1'b1, cdb_res[k*32 +: 32]};
                end
            end
        end
        return res;
    endfunction

    // Operand capture for both sources of the head instruction.
    always_comb begin
        {w_rs1_rdy, w_rs1_val} = f_capture(w_head_ins[19:15], REG_rs1_rdy, REG_rs1_val,
                                           w_byp_valid, r_last_rd, r_last_tag,
                                           CDB_sgn, CDB_result, CDB_ROB_name);
        {w_rs2_rdy, w_rs2_val} = f_capture(w_head_ins[24:20], REG_rs2_rdy, REG_rs2_val,
                                           w_byp_valid, r_last_rd, r_last_tag,
                                           CDB_sgn, CDB_result, CDB_ROB_name);
    end

    // Write the incoming instruction into the tail slot.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_ins[r_tail]   <= IF_ins;
            r_pc[r_tail]    <= IF_pc;
            r_jpc[r_tail]   <= IF_jump_pc;
            r_jflag[r_tail] <= IF_jump_flag;
        end
    end

    // Head/tail pointers and occupancy count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (rdy) begin
            if (clr) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                if (w_push) r_tail <= r_tail + 1'b1;
                if (w_pop)  r_head <= r_head + 1'b1;
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // Dispatch register, bypass record and illegal-opcode counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            DP_sgn         <= 1'b0;
            DP_ins         <= '0;
            DP_pc          <= '0;
            DP_jump_pc     <= '0;
            DP_jump_flag   <= 1'b0;
            DP_class       <= '0;
            DP_rs1_val     <= '0;
            DP_rs2_val     <= '0;
            DP_rs1_rdy     <= 1'b0;
            DP_rs2_rdy     <= 1'b0;
            DP_illegal_cnt <= '0;
            r_last_rd      <= '0;
            r_last_writes  <= 1'b0;
            r_last_tag     <= '0;
        end else if (rdy) begin
            if (w_dispatch) begin
                DP_sgn        <= 1'b1;
                DP_ins        <= w_head_ins;
                DP_pc         <= r_pc[r_head];
                DP_jump_pc    <= r_jpc[r_head];
                DP_jump_flag  <= r_jflag[r_head];
                DP_class      <= w_class;
                DP_rs1_val    <= w_rs1_val;
                DP_rs2_val    <= w_rs2_val;
                DP_rs1_rdy    <= w_rs1_rdy;
                DP_rs2_rdy    <= w_rs2_rdy;
                r_last_rd     <= w_head_ins[11:7];
                r_last_writes <= w_writes;
                r_last_tag    <= ROB_name;
            end else begin
                DP_sgn        <= 1'b0;
                r_last_rd     <= '0;
                r_last_writes <= 1'b0;
            end
            if (w_drop && (DP_illegal_cnt != 16'hFFFF)) begin
                DP_illegal_cnt <= DP_illegal_cnt + 16'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_issue_queue.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_issue_queue
//  Purpose  : Scoreboard bench for issue_queue. A queue-level reference model
//             predicts every dispatch; a monitor compares DUT dispatches in
//             order. Directed scenarios are followed by randomized traffic.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_issue_queue;

    localparam int DEPTH   = 4;
    localparam int ROB_W   = 4;
    localparam int NUM_CDB = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                     rst, rdy, clr;
    logic                     IF_ins_sgn, IF_jump_flag, IF_full;
    logic [31:0]              IF_ins, IF_pc, IF_jump_pc;
    logic                     ROB_full, RS_full, LSB_full;
    logic [ROB_W-1:0]         ROB_name;
    logic [4:0]               REG_rs1, REG_rs2;
    logic                     REG_rs1_rdy, REG_rs2_rdy;
    logic [31:0]              REG_rs1_val, REG_rs2_val;
    logic [NUM_CDB-1:0]       CDB_sgn;
    logic [NUM_CDB*32-1:0]    CDB_result;
    logic [NUM_CDB*ROB_W-1:0] CDB_ROB_name;
    logic                     DP_sgn, DP_jump_flag, DP_rs1_rdy, DP_rs2_rdy;
    logic [31:0]              DP_ins, DP_pc, DP_jump_pc, DP_rs1_val, DP_rs2_val;
    logic [1:0]               DP_class;
    logic [15:0]              DP_illegal_cnt;

    issue_queue #(.DEPTH(DEPTH), .ROB_W(ROB_W), .NUM_CDB(NUM_CDB)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .clr(clr),
        .IF_ins_sgn(IF_ins_sgn), .IF_ins(IF_ins), .IF_pc(IF_pc),
        .IF_jump_pc(IF_jump_pc), .IF_jump_flag(IF_jump_flag), .IF_full(IF_full),
        .ROB_full(ROB_full), .RS_full(RS_full), .LSB_full(LSB_full), .ROB_name(ROB_name),
        .REG_rs1(REG_rs1), .REG_rs2(REG_rs2),
        .REG_rs1_rdy(REG_rs1_rdy), .REG_rs2_rdy(REG_rs2_rdy),
        .REG_rs1_val(REG_rs1_val), .REG_rs2_val(REG_rs2_val),
        .CDB_sgn(CDB_sgn), .CDB_result(CDB_result), .CDB_ROB_name(CDB_ROB_name),
        .DP_sgn(DP_sgn), .DP_ins(DP_ins), .DP_pc(DP_pc), .DP_jump_pc(DP_jump_pc),
        .DP_jump_flag(DP_jump_flag), .DP_class(DP_class),
        .DP_rs1_val(DP_rs1_val), .DP_rs2_val(DP_rs2_val),
        .DP_rs1_rdy(DP_rs1_rdy), .DP_rs2_rdy(DP_rs2_rdy),
        .DP_illegal_cnt(DP_illegal_cnt)
    );

    typedef struct {
        logic [31:0] ins, pc, jpc;
        logic        jf;
    } ent_t;

    typedef struct {
        logic [31:0] ins, pc, jpc;
        logic        jf;
        logic [1:0]  cls;
        logic [31:0] v1, v2;
        logic        r1, r2;
    } exp_t;

    ent_t mq[$];      // model of queue contents, oldest first
    exp_t sbq[$];     // expected dispatches awaiting the monitor

    int               n_checks = 0;
    int               n_errors = 0;
    int               m_ill    = 0;
    bit               p_disp   = 0;
    bit               p_wr     = 0;
    logic [4:0]       p_rd     = '0;
    logic [ROB_W-1:0] p_tag    = '0;
    bit               exp_sgn  = 0;
    logic [31:0]      pc_ctr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int op_class(input logic [6:0] op);
        case (op)
            7'b0110111, 7'b0010111, 7'b1101111:             return 0;
            7'b1100111, 7'b1100011, 7'b0010011, 7'b0110011: return 1;
            7'b0000011, 7'b0100011:                         return 2;
            default:                                        return 3;
        endcase
    endfunction

    // Source operand rule: x0, previous-dispatch bypass, regfile, CDB, tag.
    function automatic void src_model(input logic [4:0] f, input logic rr, input logic [31:0] rv,
                                      output logic r, output logic [31:0] v);
        bit found;
        r = 1'b0;
        v = rv;
        found = 0;
        if (f == 5'd0) begin
            r = 1'b1; v = 32'd0;
        end else if (p_disp && p_wr && (p_rd == f)) begin
            r = 1'b0; v = 32'(p_tag);
        end else if (rr) begin
            r = 1'b1; v = rv;
        end else begin
            for (int k = 0; k < NUM_CDB; k++) begin
                if (!found && CDB_sgn[k] && (CDB_ROB_name[k*ROB_W +: ROB_W] == rv[ROB_W-1:0])) begin
                    found = 1; r = 1'b1; v = CDB_result[k*32 +: 32];
                end
            end
        end
    endfunction

    // Advance the reference model by one clock using the inputs now driven.
    task automatic model_step();
        ent_t h;
        exp_t e;
        int   c;
        bit   do_push, dispatched;
        if (rst) begin
            mq.delete();
            m_ill = 0; p_disp = 0; p_wr = 0; p_rd = '0; p_tag = '0; exp_sgn = 0;
        end else if (rdy) begin
            do_push    = IF_ins_sgn && (mq.size() < DEPTH) && !clr;
            dispatched = 0;
            if (clr) begin
                mq.delete();
            end else begin
                if (mq.size() > 0) begin
                    h = mq[0];
                    c = op_class(h.ins[6:0]);
                    if (c == 3) begin
                        void'(mq.pop_front());
                        if (m_ill < 65535) m_ill++;
                    end else if (!ROB_full && (c == 0 || !RS_full) && (c != 2 || !LSB_full)) begin
                        e.ins = h.ins; e.pc = h.pc; e.jpc = h.jpc; e.jf = h.jf; e.cls = 2'(c);
                        src_model(h.ins[19:15], REG_rs1_rdy, REG_rs1_val, e.r1, e.v1);
                        src_model(h.ins[24:20], REG_rs2_rdy, REG_rs2_val, e.r2, e.v2);
                        sbq.push_back(e);
                        void'(mq.pop_front());
                        dispatched = 1;
                    end
                end
                if (do_push) begin
                    h.ins = IF_ins; h.pc = IF_pc; h.jpc = IF_jump_pc; h.jf = IF_jump_flag;
                    mq.push_back(h);
                end
            end
            if (dispatched) begin
                p_disp = 1;
                p_rd   = h.ins[11:7];
                p_wr   = (h.ins[6:0] != 7'b1100011) && (h.ins[6:0] != 7'b0100011);
                p_tag  = ROB_name;
                // h was overwritten only if a push occurred; recover from scoreboard
                p_rd   = sbq[sbq.size()-1].ins[11:7];
                p_wr   = (sbq[sbq.size()-1].ins[6:0] != 7'b1100011)
                      && (sbq[sbq.size()-1].ins[6:0] != 7'b0100011);
            end else begin
                p_disp = 0; p_wr = 0; p_rd = '0;
            end
            exp_sgn = dispatched;
        end
    endtask

    task automatic do_cycle();
        model_step();
        @(posedge clk);
        #1;
        chk("dp_sgn", DP_sgn, exp_sgn);
        chk("if_full", IF_full, mq.size() == DEPTH);
        chk("illegal_cnt", DP_illegal_cnt, m_ill);
    endtask

    task automatic idle();
        rst = 0; rdy = 1; clr = 0; IF_ins_sgn = 0;
        ROB_full = 0; RS_full = 0; LSB_full = 0; ROB_name = '0;
        REG_rs1_rdy = 1; REG_rs2_rdy = 1; REG_rs1_val = '0; REG_rs2_val = '0;
        CDB_sgn = '0; CDB_result = '0; CDB_ROB_name = '0;
    endtask

    task automatic push(input logic [31:0] ins);
        IF_ins_sgn   = 1;
        IF_ins       = ins;
        IF_pc        = pc_ctr;
        pc_ctr       = pc_ctr + 32'd4;
        IF_jump_pc   = $urandom;
        IF_jump_flag = 1'($urandom_range(0, 1));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_sgn"},   DP_sgn, 0);
        chk({tag, "_ins"},   DP_ins, 0);
        chk({tag, "_pc"},    DP_pc, 0);
        chk({tag, "_jpc"},   DP_jump_pc, 0);
        chk({tag, "_jf"},    DP_jump_flag, 0);
        chk({tag, "_cls"},   DP_class, 0);
        chk({tag, "_v1"},    DP_rs1_val, 0);
        chk({tag, "_v2"},    DP_rs2_val, 0);
        chk({tag, "_r1"},    DP_rs1_rdy, 0);
        chk({tag, "_r2"},    DP_rs2_rdy, 0);
        chk({tag, "_ill"},   DP_illegal_cnt, 0);
        chk({tag, "_full"},  IF_full, 0);
    endtask

    // Monitor: every fresh dispatch pulse is matched against the scoreboard.
    initial begin : monitor
        logic edge_rdy, edge_rst;
        exp_t e;
        forever begin
            @(posedge clk);
            edge_rdy = rdy;
            edge_rst = rst;
            @(negedge clk);
            if (DP_sgn === 1'b1 && edge_rdy && !edge_rst) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_dispatch", DP_pc, 32'hFFFF_FFFF);
                end else begin
                    e = sbq.pop_front();
                    chk("dp_ins", DP_ins, e.ins);
                    chk("dp_pc", DP_pc, e.pc);
                    chk("dp_jump_pc", DP_jump_pc, e.jpc);
                    chk("dp_jump_flag", DP_jump_flag, e.jf);
                    chk("dp_class", DP_class, e.cls);
                    chk("dp_rs1_val", DP_rs1_val, e.v1);
                    chk("dp_rs1_rdy", DP_rs1_rdy, e.r1);
                    chk("dp_rs2_val", DP_rs2_val, e.v2);
                    chk("dp_rs2_rdy", DP_rs2_rdy, e.r2);
                end
            end
        end
    end

    logic [6:0] ops [11];

    initial begin : driver
        logic [31:0] ins;
        ops = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011, 7'b0010011,
                7'b0110011, 7'b0000011, 7'b0100011, 7'b1111111, 7'b0000000};
        pc_ctr = 32'h1000;
        IF_ins = '0; IF_pc = '0; IF_jump_pc = '0; IF_jump_flag = 0;
        idle();
        rst = 1;
        do_cycle();
        do_cycle();
        chk_zero("reset");
        idle();

        // fill and drain with the ROB blocked
        ROB_full = 1;
        for (int i = 0; i < 5; i++) begin
            push(32'h00000013 | ((i + 1) << 7));
            do_cycle();
            if (i == 3) chk("fill_full_4th", IF_full, 1);
        end
        chk("fill_5th_dropped", IF_full, 1);
        IF_ins_sgn = 0;
        ROB_full   = 0;
        for (int i = 0; i < 4; i++) begin
            do_cycle();
            chk("drain_order_pc", DP_pc, 32'h1000 + 4 * i);
        end
        do_cycle();
        chk("drain_done", DP_sgn, 0);

        // dependency bypass: addi x5,x0,1 then add x6,x5,x5
        ROB_full = 1;
        push(32'h00100293); do_cycle();
        push(32'h00528333); do_cycle();
        IF_ins_sgn = 0; ROB_full = 0; ROB_name = 4'd3;
        REG_rs1_rdy = 1; REG_rs1_val = 32'd9; REG_rs2_rdy = 1; REG_rs2_val = 32'd9;
        do_cycle();
        ROB_name = 4'd4;
        do_cycle();
        chk("byp_rs1_val", DP_rs1_val, 3);
        chk("byp_rs1_rdy", DP_rs1_rdy, 0);
        chk("byp_rs2_val", DP_rs2_val, 3);
        chk("byp_rs2_rdy", DP_rs2_rdy, 0);

        // CDB capture: both channels carry tag 2, channel 0 wins
        idle(); ROB_full = 1;
        push(32'h00038413); do_cycle();
        IF_ins_sgn = 0; ROB_full = 0;
        REG_rs1_rdy = 0; REG_rs1_val = 32'd2;
        CDB_sgn = 2'b11; CDB_ROB_name = {4'd2, 4'd2}; CDB_result = {32'h22, 32'h11};
        do_cycle();
        chk("cdb_rs1_val", DP_rs1_val, 32'h11);
        chk("cdb_rs1_rdy", DP_rs1_rdy, 1);

        // structural stall on a LOAD with the LSB full
        idle(); LSB_full = 1;
        push(32'h00008483); do_cycle();
        IF_ins_sgn = 0;
        for (int i = 0; i < 3; i++) begin
            do_cycle();
            chk("stall_no_dp", DP_sgn, 0);
        end
        LSB_full = 0;
        do_cycle();
        chk("stall_dp", DP_sgn, 1);
        chk("stall_class", DP_class, 2);

        // flush with three queued and a simultaneous push
        idle(); ROB_full = 1;
        for (int i = 0; i < 3; i++) begin
            push(32'h00000093); do_cycle();
        end
        clr = 1; push(32'h00000093);
        do_cycle();
        chk("flush_full", IF_full, 0);
        chk("flush_dp", DP_sgn, 0);
        idle();
        do_cycle();
        chk("flush_empty_dp", DP_sgn, 0);

        // illegal opcode drop, then reset with two entries queued
        idle(); rst = 1; do_cycle(); idle();
        ROB_full = 1;
        push(32'h0000007F); do_cycle();
        IF_ins_sgn = 0; do_cycle();
        chk("illegal_cnt_one", DP_illegal_cnt, 1);
        chk("illegal_no_dp", DP_sgn, 0);
        ROB_full = 0;
        push(32'hABC00093); do_cycle();
        IF_ins_sgn = 0; REG_rs1_val = 32'h55; do_cycle();
        ROB_full = 1;
        push(32'h00000093); do_cycle();
        push(32'h00000093); do_cycle();
        rst = 1; IF_ins_sgn = 0;
        do_cycle();
        chk_zero("rst_mid");
        idle();
        do_cycle();
        chk("rst_empty_dp", DP_sgn, 0);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            idle();
            rst      = ($urandom_range(0, 199) == 0);
            clr      = ($urandom_range(0, 49) == 0);
            rdy      = ($urandom_range(0, 9) != 0);
            ROB_full = ($urandom_range(0, 3) == 0);
            RS_full  = ($urandom_range(0, 3) == 0);
            LSB_full = ($urandom_range(0, 3) == 0);
            ROB_name = ROB_W'($urandom);
            REG_rs1_rdy = 1'($urandom_range(0, 1));
            REG_rs2_rdy = 1'($urandom_range(0, 1));
            REG_rs1_val = REG_rs1_rdy ? $urandom : (($urandom & 32'hFFFF_FFF0) | $urandom_range(0, 3));
            REG_rs2_val = REG_rs2_rdy ? $urandom : (($urandom & 32'hFFFF_FFF0) | $urandom_range(0, 3));
            CDB_sgn      = NUM_CDB'($urandom);
            CDB_ROB_name = {4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))};
            CDB_result   = {$urandom, $urandom};
            if ($urandom_range(0, 3) != 0) begin
                ins        = $urandom;
                ins[6:0]   = ops[$urandom_range(0, 10)];
                ins[11:7]  = 5'($urandom_range(0, 7));
                ins[19:15] = 5'($urandom_range(0, 7));
                ins[24:20] = 5'($urandom_range(0, 7));
                push(ins);
            end
            do_cycle();
        end

        // drain and confirm nothing is left outstanding
        idle();
        repeat (DEPTH + 3) do_cycle();
        @(negedge clk);
        chk("scoreboard_empty", sbq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
